// File: rtl/adder_share_arbiter.sv
// Round-robin scheduler sharing one registered WIDTH-bit adder among NREQ requesters.
// One operation in flight at a time; results leave over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for any req; picks round-robin winner and latches its operands
// CALC  | grant pulse to the winner; sum registered at the end of this cycle
// DONE  | result held with res_valid until res_ready
module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int CNTW  = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_c,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH:0]        res,
  output logic [IDW-1:0]        res_id,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNTW-1:0]       done_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   cand;
  logic             win_found;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_c;

  // First requester at or after rr_ptr, wrapping; rr_ptr already skips the last winner.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears them without waiting for a clock.
  always_comb begin
    gnt       = '0;
    busy      = (state != IDLE);
    res_valid = (state == DONE);
    if (state == CALC) gnt[res_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_a    <= '0;
      lat_c    <= '0;
      res      <= '0;
      res_id   <= '0;
      done_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            lat_a  <= op_a[int'(win_id)*WIDTH +: WIDTH];
            lat_c  <= op_c[int'(win_id)*WIDTH +: WIDTH];
            res_id <= win_id;
          end
        end
        CALC: res <= {1'b0, lat_a} + {1'b0, lat_c};
        DONE: begin
          if (res_ready) begin
            done_cnt <= done_cnt + CNTW'(1);
            rr_ptr   <= (res_id == IDW'(NREQ - 1)) ? '0 : res_id + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: vector table plus directed round-robin,
// backpressure, reset and counter-wrap sequences, results checked via a scoreboard.
module tb_adder_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] op_a, op_c;
  logic [3:0]  gnt;
  logic        busy;
  logic [4:0]  res;
  logic [1:0]  res_id;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  done_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_done;

  typedef struct { int id; logic [3:0] a; logic [3:0] c; logic [4:0] r; } vec_t;
  typedef struct { logic [1:0] id; logic [4:0] r; } exp_t;
  vec_t tbl[6];
  exp_t sb[$];

  adder_share_arbiter #(.NREQ(4), .WIDTH(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_c(op_c),
    .gnt(gnt), .busy(busy), .res(res), .res_id(res_id),
    .res_valid(res_valid), .res_ready(res_ready), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted result must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {27'd0, res}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_res", {27'd0, res}, {27'd0, e.r});
          chk("sb_res_id", {30'd0, res_id}, {30'd0, e.id});
        end
      end
    end
  end

  task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] c);
    op_a[id*4 +: 4] = a;
    op_c[id*4 +: 4] = c;
  endtask

  task automatic wait_gnt(input int id, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!gnt[id] && lat < 20);
    if (!gnt[id]) chk("gnt_timeout", {28'd0, gnt}, 32'd1 << id);
  endtask

  task automatic wait_any();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == 4'd0 && k < 20);
    if (gnt == 4'd0) chk("any_gnt_timeout", {28'd0, gnt}, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 20);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] c, input logic [4:0] r);
    int lat;
    set_ops(id, a, c);
    res_ready = 1'b1;
    sb.push_back('{2'(id), r});
    req[id] = 1'b1;
    wait_gnt(id, lat);
    chk("gnt_latency", lat, 1);
    chk("gnt_onehot", {28'd0, gnt}, 32'd1 << id);
    req[id] = 1'b0;
    set_ops(id, ~a, ~c);
    @(negedge clk);
    chk("res_valid_rise", {31'd0, res_valid}, 32'd1);
    @(negedge clk);
    chk("idle_after_hs", {30'd0, busy, res_valid}, 32'd0);
    exp_done++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    chk("rst_outputs", {gnt, busy, res, res_id, res_valid, done_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_done = '0;
  endtask

  initial begin
    tbl[0] = '{0, 4'd5, 4'd4, 5'd9};
    tbl[1] = '{2, 4'hF, 4'hF, 5'h1E};
    tbl[2] = '{1, 4'd7, 4'd8, 5'h0F};
    tbl[3] = '{3, 4'd0, 4'd0, 5'h00};
    tbl[4] = '{3, 4'hF, 4'h1, 5'h10};
    tbl[5] = '{0, 4'hA, 4'h6, 5'h10};

    rst = 1'b1; req = '0; op_a = '0; op_c = '0; res_ready = 1'b0; exp_done = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", {27'd0, res}, 32'd0);
    chk("rst_res_id", {30'd0, res_id}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_gnt", {28'd0, gnt}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_valid", {31'd0, res_valid}, 32'd0);
      chk("idle_cnt", {24'd0, done_cnt}, 32'd0);
    end

    for (int i = 0; i < 6; i++) run_one(tbl[i].id, tbl[i].a, tbl[i].c, tbl[i].r);
    chk("cnt_after_table", {24'd0, done_cnt}, {24'd0, exp_done});

    // Round robin with every requester active, starting from rr_ptr=0.
    pulse_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a4, c4;
      a4 = 4'(i + 1);
      c4 = 4'(2 * i + 3);
      set_ops(i, a4, c4);
      sb.push_back('{2'(i), {1'b0, a4} + {1'b0, c4}});
    end
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_any();
      chk("rr_order", {28'd0, gnt}, 32'd1 << n);
      req[n] = 1'b0;
    end
    wait_idle();
    exp_done += 8'd4;
    chk("rr_cnt", {24'd0, done_cnt}, {24'd0, exp_done});

    set_ops(0, 4'd2, 4'd3);
    set_ops(3, 4'd9, 4'd9);
    sb.push_back('{2'd0, 5'd5});
    sb.push_back('{2'd3, 5'd18});
    req = 4'b1001;
    wait_any();
    chk("rr_wrap_first", {28'd0, gnt}, 32'b0001);
    req[0] = 1'b0;
    wait_any();
    chk("rr_wrap_second", {28'd0, gnt}, 32'b1000);
    req[3] = 1'b0;
    wait_idle();
    exp_done += 8'd2;

    // Backpressure: result held while req1 waits.
    begin
      int lat;
      res_ready = 1'b0;
      set_ops(2, 4'd3, 4'd2);
      sb.push_back('{2'd2, 5'd5});
      req[2] = 1'b1;
      wait_gnt(2, lat);
      req[2] = 1'b0;
      set_ops(1, 4'd1, 4'd1);
      sb.push_back('{2'd1, 5'd2});
      req[1] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        chk("bp_res", {27'd0, res}, 32'd5);
        chk("bp_res_id", {30'd0, res_id}, 32'd2);
        chk("bp_no_gnt", {28'd0, gnt}, 32'd0);
        chk("bp_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp_gap", {28'd0, gnt}, 32'd0);
      @(negedge clk);
      chk("bp_next_gnt", {28'd0, gnt}, 32'b0010);
      req[1] = 1'b0;
      wait_idle();
      exp_done += 8'd2;
      chk("bp_cnt", {24'd0, done_cnt}, {24'd0, exp_done});
    end

    // Reset during CALC: nothing completes, rr_ptr returns to 0.
    begin
      int lat;
      set_ops(1, 4'd3, 4'd6);
      res_ready = 1'b1;
      req[1] = 1'b1;
      wait_gnt(1, lat);
      rst = 1'b1;
      req = '0;
      #1;
      chk("midrst_outputs", {gnt, busy, res, res_id, res_valid, done_cnt}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("midrst_no_valid", {31'd0, res_valid}, 32'd0);
      end
      rst = 1'b0;
      exp_done = '0;
      set_ops(1, 4'd2, 4'd2);
      set_ops(3, 4'd5, 4'd5);
      sb.push_back('{2'd1, 5'd4});
      sb.push_back('{2'd3, 5'd10});
      req = 4'b1010;
      wait_any();
      chk("midrst_first", {28'd0, gnt}, 32'b0010);
      req[1] = 1'b0;
      wait_any();
      chk("midrst_second", {28'd0, gnt}, 32'b1000);
      req[3] = 1'b0;
      wait_idle();
      exp_done += 8'd2;
      chk("midrst_cnt", {24'd0, done_cnt}, {24'd0, exp_done});
    end

    // Counter wrap: 256 more completions bring done_cnt back to the same value.
    for (int k = 0; k < 256; k++) begin
      logic [3:0] a4, c4;
      a4 = 4'(k);
      c4 = 4'(k >> 4);
      run_one(k % 4, a4, c4, {1'b0, a4} + {1'b0, c4});
    end
    chk("wrap_cnt", {24'd0, done_cnt}, 32'd2);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Round-robin scheduler that shares one registered WIDTH-bit adder (sum = a + c) among NREQ requesters.
- Each requester raises req with its operand pair.
- The block grants one requester at a time, latches its operands, computes the sum and presents the result with a valid/ready handshake.
- Sits between the operand producers and the shared adder datapath. Also keeps a wrap-around count of completed operations for debug.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits.
- CNTW, 8, width of completed-operation counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request; bit i held high until gnt[i].
- op_a  in  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
- op_c  in  NREQ*WIDTH  operand c; same packing as op_a.
- gnt  out  NREQ  one-hot, single-cycle grant pulse.
- busy  out  1  high whenever state != IDLE.
- res  out  WIDTH+1  registered sum including carry-out.
- res_id  out  clog2(NREQ)  index of the requester that owns res.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- done_cnt  out  CNTW  number of completed handshakes, wraps modulo 2^CNTW.

Behaviour:
- Reset (async assert, all outputs take reset values immediately):
  - state=IDLE, gnt=0, busy=0, res=0, res_id=0, res_valid=0, done_cnt=0, rr_ptr=0.
  - Reset mid-operation discards any latched operands and any pending result.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If req != 0 at a posedge, select winner w = first set bit searching from rr_ptr upward, wrapping NREQ-1 to 0.
  - On that edge: latch op_a[w] and op_c[w], set res_id=w, gnt=onehot(w), and go to CALC.
  - If req == 0, stay in IDLE.
- CALC (exactly 1 cycle):
  - gnt is high for this cycle only.
  - At the next edge: res = {1'b0,a} + {1'b0,c} (full WIDTH+1 bits, no truncation), res_valid=1, gnt=0, go to DONE.
- DONE:
  - res, res_id and res_valid are held stable until res_ready=1 at a posedge.
  - On that edge: res_valid=0, done_cnt++ (wraps), rr_ptr=(res_id+1) mod NREQ, go to IDLE.
  - res_ready high on the first DONE cycle still counts as a handshake.
- Latency: from the posedge sampling req in IDLE, gnt is high during the next cycle and res_valid rises one cycle later (2 cycles).
- Minimum issue interval is 3 cycles (IDLE, CALC, DONE) when res_ready is held high.
- Requests are not sampled in CALC or DONE. A requester still waiting is considered again on return to IDLE.
- A req bit dropped before its grant is simply not granted; there is no error.
- Fairness: the previous winner has lowest priority. With all bits requesting, the grant order is 0,1,2,3,0,...
- res_ready while res_valid=0 is ignored.
- Operand changes after the latch edge do not affect res.

Test Plan:
- Reset then idle: rst pulse, req=0 for 10 cycles -> gnt=0, busy=0, res_valid=0, done_cnt=0 throughout.
- Single request: req=4'b0001, a0=5, c0=4, res_ready=1 -> gnt=4'b0001 for 1 cycle, then res=5'd9, res_id=0, res_valid for 1 cycle, done_cnt=1.
- Overflow: req[2], a2=4'hF, c2=4'hF -> res=5'h1E, res_id=2.
- Round robin: req=4'b1111 held, each requester drops req on its grant, res_ready=1 -> grant order 0,1,2,3, then done_cnt=4. Re-raise req0 and req3 with rr_ptr=0 -> req0 granted before req3.
- Backpressure: res_ready=0 for 5 cycles in DONE while req1 is high -> res/res_id stable, no new gnt. res_ready=1 -> handshake, gnt[1] two cycles later.
- Reset mid-op: assert rst during CALC with a=3, c=6 -> res_valid never rises, all outputs 0 immediately, next grant search starts at index 0.
